// File: rtl/bitplane_mac_seq.sv
// bitplane_mac_seq: walks every input-bit x weight-bit x element step of a precision-scalable MAC
module bitplane_mac_seq #(
  parameter int MAXP = 8,
  parameter int PW   = 4,
  parameter int BW   = 3,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [PW-1:0]   cfg_pi,
  input  logic [PW-1:0]   cfg_pw,
  input  logic            cfg_si,
  input  logic            cfg_sw,
  input  logic            cfg_bin,
  input  logic [LENW-1:0] cfg_len,
  output logic            step_valid,
  input  logic            step_ready,
  output logic [BW-1:0]   i_sel,
  output logic [BW-1:0]   w_sel,
  output logic            sign_i,
  output logic            sign_w,
  output logic            bin,
  output logic [BW:0]     shift,
  output logic            neg,
  output logic            acc_clr,
  output logic            acc_last,
  output logic [LENW-1:0] elem,
  output logic            done,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pi_q, pw_q, c_pi, c_pw;
  logic [LENW-1:0] len_q, c_len, e_q, e_d;
  logic si_q, sw_q, bin_q, c_si, c_sw, c_bin;
  logic [BW-1:0] i_q, i_d, w_q, w_d;
  logic v_q, v_d, rdy_q, done_q, done_d, err_q, err_d;
  logic sign_i_q, sign_i_d, sign_w_q, sign_w_d, neg_q, neg_d, bin_o_q, bin_o_d;
  logic clr_q, clr_d, last_q, last_d;
  logic [BW:0] shift_q, shift_d;
  logic accept, illegal, hs, w_end, i_end;
  assign accept  = state_q == IDLE && cfg_valid && rdy_q;
  assign illegal = cfg_pi == '0 || cfg_pw == '0 || cfg_len == '0 ||
                   cfg_pi > PW'(MAXP) || cfg_pw > PW'(MAXP);
  assign hs      = v_q && step_ready;
  assign w_end   = PW'(w_q) == pw_q - PW'(1);
  assign i_end   = PW'(i_q) == pi_q - PW'(1);
  // Flags for the first step are derived from the incoming configuration, later ones from the latched copy
  assign c_pi  = accept ? (cfg_bin ? PW'(1) : cfg_pi) : pi_q;
  assign c_pw  = accept ? (cfg_bin ? PW'(1) : cfg_pw) : pw_q;
  assign c_si  = accept ? cfg_si & ~cfg_bin : si_q;
  assign c_sw  = accept ? cfg_sw & ~cfg_bin : sw_q;
  assign c_bin = accept ? cfg_bin : bin_q;
  assign c_len = accept ? cfg_len : len_q;
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    w_d     = w_q;
    e_d     = e_q;
    v_d     = v_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = illegal ? DONE : RUN;
        v_d     = ~illegal;
        done_d  = illegal;
        err_d   = illegal;
      end
      RUN: if (hs) begin
        state_d = last_q ? DONE : RUN;
        v_d     = ~last_q;
        done_d  = last_q;
        w_d     = (last_q || w_end) ? '0 : w_q + BW'(1);
        i_d     = last_q ? '0 : w_end ? (i_end ? '0 : i_q + BW'(1)) : i_q;
        e_d     = last_q ? '0 : (w_end && i_end) ? e_q + LENW'(1) : e_q;
      end
      default: state_d = IDLE;
    endcase
    sign_i_d = v_d & c_si & (PW'(i_d) == c_pi - PW'(1));
    sign_w_d = v_d & c_sw & (PW'(w_d) == c_pw - PW'(1));
    neg_d    = sign_i_d ^ sign_w_d;
    bin_o_d  = v_d & c_bin;
    shift_d  = {1'b0, i_d} + {1'b0, w_d};
    clr_d    = v_d & ~|i_d & ~|w_d & ~|e_d;
    last_d   = v_d & (e_d == c_len - LENW'(1)) & (PW'(i_d) == c_pi - PW'(1)) &
               (PW'(w_d) == c_pw - PW'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      {pi_q, pw_q, si_q, sw_q, bin_q, len_q} <= '0;
      {i_q, w_q, e_q, v_q, rdy_q, done_q, err_q} <= '0;
      {sign_i_q, sign_w_q, neg_q, bin_o_q, shift_q, clr_q, last_q} <= '0;
    end else begin
      state_q  <= state_d;
      if (accept) {pi_q, pw_q, si_q, sw_q, bin_q, len_q} <= {c_pi, c_pw, c_si, c_sw, c_bin, c_len};
      i_q      <= i_d;
      w_q      <= w_d;
      e_q      <= e_d;
      v_q      <= v_d;
      rdy_q    <= state_d == IDLE;
      done_q   <= done_d;
      err_q    <= err_d;
      sign_i_q <= sign_i_d;
      sign_w_q <= sign_w_d;
      neg_q    <= neg_d;
      bin_o_q  <= bin_o_d;
      shift_q  <= shift_d;
      clr_q    <= clr_d;
      last_q   <= last_d;
    end
  end
  assign cfg_ready  = rdy_q;
  assign step_valid = v_q;
  assign i_sel      = i_q;
  assign w_sel      = w_q;
  assign elem       = e_q;
  assign sign_i     = sign_i_q;
  assign sign_w     = sign_w_q;
  assign neg        = neg_q;
  assign bin        = bin_o_q;
  assign shift      = shift_q;
  assign acc_clr    = clr_q;
  assign acc_last   = last_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_bitplane_mac_seq.sv
// tb_bitplane_mac_seq: directed table-driven checks of the bit-plane sequencer
module tb_bitplane_mac_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_si = 1'b0, cfg_sw = 1'b0, cfg_bin = 1'b0, step_ready = 1'b0;
  logic [3:0] cfg_pi = '0, cfg_pw = '0;
  logic [7:0] cfg_len = '0;
  logic cfg_ready, step_valid, sign_i, sign_w, bin, neg, acc_clr, acc_last, done, err;
  logic [2:0] i_sel, w_sel;
  logic [3:0] shift;
  logic [7:0] elem;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bitplane_mac_seq dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pi(cfg_pi), .cfg_pw(cfg_pw), .cfg_si(cfg_si), .cfg_sw(cfg_sw),
    .cfg_bin(cfg_bin), .cfg_len(cfg_len), .step_valid(step_valid),
    .step_ready(step_ready), .i_sel(i_sel), .w_sel(w_sel), .sign_i(sign_i),
    .sign_w(sign_w), .bin(bin), .shift(shift), .neg(neg), .acc_clr(acc_clr),
    .acc_last(acc_last), .elem(elem), .done(done), .err(err)
  );

  typedef struct {int pi; int pw; bit si; bit sw; bit b; int len; bit tog; bit e; int n;} vec_t;
  typedef struct {int i; int w; int sh; bit ng; bit clr; bit last;} st_t;
  vec_t tbl[11];
  st_t st[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fields();
    return {7'b0, step_valid, i_sel, w_sel, sign_i, sign_w, bin, shift, neg, acc_clr, acc_last, elem};
  endfunction

  function automatic logic [31:0] expf(input int i, input int w, input int e, input bit si,
                                       input bit sw, input bit b, input int pi, input int pw,
                                       input int len);
    bit sgi, sgw, clr, last;
    sgi  = si && i == pi - 1;
    sgw  = sw && w == pw - 1;
    clr  = e == 0 && i == 0 && w == 0;
    last = e == len - 1 && i == pi - 1 && w == pw - 1;
    return {7'b0, 1'b1, 3'(i), 3'(w), sgi, sgw, b, 4'(i + w), sgi ^ sgw, clr, last, 8'(e)};
  endfunction

  task automatic start(input int pi, input int pw, input bit si, input bit sw, input bit b,
                       input int len);
    int n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    cfg_pi = 4'(pi); cfg_pw = 4'(pw); cfg_si = si; cfg_sw = sw; cfg_bin = b; cfg_len = 8'(len);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int epi, epw, k, e, i, w, cyc;
    bit esi, esw, phase, rdy;
    epi = v.b ? 1 : v.pi; epw = v.b ? 1 : v.pw;
    esi = v.si & ~v.b;    esw = v.sw & ~v.b;
    start(v.pi, v.pw, v.si, v.sw, v.b, v.len);
    k = 0; e = 0; i = 0; w = 0; cyc = 0; phase = 1'b1;
    while (k < v.n && cyc < 4 * v.n + 20) begin
      chk("step", fields(), expf(i, w, e, esi, esw, v.b, epi, epw, v.len));
      rdy = v.tog ? phase : 1'b1;
      phase = ~phase;
      step_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        k++;
        if (w == epw - 1) begin
          w = 0;
          if (i == epi - 1) begin i = 0; e++; end else i++;
        end else w++;
      end
    end
    step_ready = 1'b0;
    chk("done_time", cyc, v.tog ? 2 * v.n - 1 : v.n);
    chk("done", {done, err, step_valid}, 3'b100);
    @(negedge clk);
    chk("idle", {cfg_ready, done, step_valid}, 3'b100);
  endtask

  task automatic run_err(input vec_t v);
    start(v.pi, v.pw, v.si, v.sw, v.b, v.len);
    chk("err_pulse", {cfg_ready, done, err, step_valid}, 4'b0110);
    @(negedge clk);
    chk("err_idle", {cfg_ready, done, err, step_valid}, 4'b1000);
  endtask

  initial begin
    int last_done, ndone;
    tbl[0]  = '{2, 3, 1, 1, 0, 1,   0, 0, 6};
    tbl[1]  = '{4, 4, 1, 1, 1, 3,   0, 0, 3};
    tbl[2]  = '{8, 8, 0, 0, 0, 2,   1, 0, 128};
    tbl[3]  = '{0, 3, 0, 0, 0, 1,   0, 1, 0};
    tbl[4]  = '{2, 2, 0, 0, 0, 0,   0, 1, 0};
    tbl[5]  = '{9, 1, 0, 0, 0, 1,   0, 1, 0};
    tbl[6]  = '{1, 9, 0, 0, 0, 1,   0, 1, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 1,   0, 0, 1};
    tbl[8]  = '{3, 1, 0, 1, 0, 2,   1, 0, 6};
    tbl[9]  = '{8, 8, 1, 1, 0, 1,   0, 0, 64};
    tbl[10] = '{1, 3, 0, 0, 0, 255, 0, 0, 765};
    st[0] = '{0, 0, 0, 0, 1, 0};
    st[1] = '{0, 1, 1, 0, 0, 0};
    st[2] = '{0, 2, 2, 1, 0, 0};
    st[3] = '{1, 0, 1, 1, 0, 0};
    st[4] = '{1, 1, 2, 1, 0, 0};
    st[5] = '{1, 2, 3, 0, 0, 1};
    repeat (3) @(negedge clk);
    chk("rst_state", {fields(), cfg_ready, done, err}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cfg_ready, 1);

    start(2, 3, 1, 1, 0, 1);
    step_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t23_ij", {i_sel, w_sel}, {3'(st[k].i), 3'(st[k].w)});
      chk("t23_shift", shift, st[k].sh);
      chk("t23_flags", {neg, acc_clr, acc_last, step_valid}, {st[k].ng, st[k].clr, st[k].last, 1'b1});
      @(negedge clk);
    end
    step_ready = 1'b0;
    chk("t23_done", {done, err, step_valid}, 3'b100);
    @(negedge clk);

    for (int t = 0; t < 11; t++)
      if (tbl[t].e) run_err(tbl[t]); else run_op(tbl[t]);

    start(4, 4, 1, 1, 0, 5);
    step_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_rst", {step_valid, elem, i_sel, w_sel}, {1'b1, 8'd1, 3'd1, 3'd0});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", {fields(), cfg_ready, done, err}, '0);
    rst = 1'b0;
    step_ready = 1'b0;
    @(negedge clk);
    chk("post_rst", {cfg_ready, done, step_valid}, 3'b100);
    run_op(tbl[7]);

    cfg_pi = 4'd1; cfg_pw = 4'd1; cfg_si = 1'b0; cfg_sw = 1'b0; cfg_bin = 1'b0; cfg_len = 8'd2;
    cfg_valid = 1'b1;
    step_ready = 1'b1;
    last_done = -1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (cfg_ready && last_done >= 0) chk("b2b_gap", c - last_done, 1);
      if (done) begin ndone++; last_done = c; end
      chk("b2b_excl", cfg_ready & (step_valid | done), 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    step_ready = 1'b0;
    chk("b2b_count", ndone, 5);
    chk("b2b_end", {cfg_ready, step_valid}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitplane_mac_seq.md
# bitplane_mac_seq

Bit-plane sequencer for the 1-bit multiplier array. It accepts one operation configuration and walks every input-bit × weight-bit pair of a precision-scalable multiply-accumulate over a vector of elements. Each step it drives the bit selects, sign-extension flags, binary (XNOR) mode and shift amount to the multiplier/accumulator datapath, under backpressure. It sits between the layer control FSM and the BitBlade multiplier/shift-add accumulator.

## Interface
- `MAXP`, default 8: maximum operand precision in bits.
- `PW`, default 4: width of precision fields; must hold the value MAXP.
- `BW`, default 3: width of bit-index outputs, equal to clog2(MAXP).
- `LENW`, default 8: width of the element count.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  sequencer idle and able to accept a configuration.
- `cfg_pi`  in  PW  input precision in bits, legal range 1..MAXP.
- `cfg_pw`  in  PW  weight precision in bits, legal range 1..MAXP.
- `cfg_si`  in  1  input operand is two's complement.
- `cfg_sw`  in  1  weight operand is two's complement.
- `cfg_bin`  in  1  binary mode: XNOR multiply, precision forced to 1×1.
- `cfg_len`  in  LENW  number of vector elements, legal range 1..2^LENW−1.
- `step_valid`  out  1  step fields are valid.
- `step_ready`  in  1  datapath consumes the step.
- `i_sel`  out  BW  input bit index.
- `w_sel`  out  BW  weight bit index.
- `sign_i`  out  1  SignI to the multiplier.
- `sign_w`  out  1  SignW to the multiplier.
- `bin`  out  1  bin select to the multiplier.
- `shift`  out  BW+1  left shift of the partial product; equals i_sel + w_sel.
- `neg`  out  1  partial product carries negative weight.
- `acc_clr`  out  1  first step of the operation.
- `acc_last`  out  1  final step of the operation.
- `elem`  out  LENW  current element index.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  illegal configuration; valid only while done is high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `cfg_valid && cfg_ready` with a legal configuration. All configuration fields are latched on that edge.
- IDLE → DONE with `err=1` when `cfg_pi`, `cfg_pw` or `cfg_len` is 0, or when `cfg_pi` or `cfg_pw` exceeds MAXP. No steps are issued.
- When `cfg_bin=1`, the effective precisions are 1×1 and `cfg_si` and `cfg_sw` are ignored (treated as 0).
- Loop order: `w_sel` is the innermost loop (0..PW−1), then `i_sel` (0..PI−1), then `elem` (0..LEN−1). Total steps = LEN × PI × PW.
- All counters start at 0.
- `sign_i` = latched si AND (i_sel == PI−1).
- `sign_w` = latched sw AND (w_sel == PW−1).
- `neg` = sign_i XOR sign_w. A signed MSB × signed MSB product is positive.
- `bin` = latched bin for the whole operation.
- `acc_clr` = 1 only on step (elem 0, i 0, w 0).
- `acc_last` = 1 only on step (LEN−1, PI−1, PW−1).
- Counters advance only on a `step_valid && step_ready` handshake.
- RUN → DONE on the handshake of the `acc_last` step.
- DONE → IDLE unconditionally after one cycle.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - State is IDLE.
  - `cfg_ready`=0.
  - All step outputs, `done` and `err` = 0.
  - `cfg_ready` rises in the first cycle after `rst` deasserts.
- All outputs are registered.
- `cfg_ready`=1 only in IDLE. It drops in the cycle after acceptance.
- First step appears with `step_valid=1` in cycle T+1, where T is the acceptance edge.
- With `step_ready` held high, one step issues per cycle. `done` is high in cycle T+1+N, where N is the step count, then `cfg_ready` is high in cycle T+2+N.
- Illegal configuration: `done=err=1` in cycle T+1, `cfg_ready` high in cycle T+2.
- Stall: while `step_valid && !step_ready`, every step output holds stable.
- `step_valid` never drops without a handshake.
- `rst` asserted mid-RUN aborts the operation the next edge. No `done` is produced and the partial accumulation is discarded by the datapath.
- A `cfg_valid` that is high in RUN or DONE is ignored, not queued.

## Test plan
- Signed 2×3, len 1, `step_ready`=1 → six steps with (i,w) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2):
  - shift = 0,1,2,1,2,3.
  - neg = 0,0,1,1,1,0.
  - acc_clr on step 1, acc_last on step 6, done at T+7.
- Binary mode, pi=pw=4, len=3 → three steps, all with i=w=0, bin=1, sign_i=sign_w=neg=0, elem=0,1,2, done at T+4.
- Unsigned 8×8, len 2, with `step_ready` toggled 1/0 each cycle → 128 steps with no step lost or repeated, outputs held during stalls, neg always 0.
- cfg_pi=0 (also repeat with cfg_len=0) → no step_valid, done=err=1 at T+1, cfg_ready=1 at T+2.
- Signed 4×4, len 5, `rst` pulsed at step 20 → all outputs zero, no done, cfg_ready=1 after rst deasserts, and a new 1×1 configuration then completes normally.
- cfg_valid held high continuously across back-to-back operations → each configuration is accepted only in IDLE, and done precedes each re-acceptance by exactly one cycle.
